// File: rtl/mem_responder.sv
// mem_responder
//   Dual-port register-file responder on the memory side of the
//   read_rq/write_rq request interface. Reads are registered (1-cycle
//   latency), written entries are tracked in valid_mask, bad accesses are
//   flagged, and completed transactions are counted with saturation.
//
//   Build option: define MEM_BYPASS_EN for write-first behaviour on a
//   same-address read/write collision. Without it the collision is
//   read-first: the read sees the contents from before the write.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   write_rq    write request
//   w_address   write address
//   write_data  write data
//   read_rq     read request
//   r_address   read address
//   read_data   registered read data (holds when no read is requested)
//   read_valid  read_data carries a good read result this cycle
//   read_err    previous read was out of range or hit an unwritten entry
//   write_err   previous write was out of range (1-cycle pulse)
//   valid_mask  bit i set once entry i has been written since reset
//   wr_count    accepted writes, saturating
//   rd_count    good reads, saturating
module mem_responder #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_rq,
  input  logic [ADDR_WIDTH-1:0] w_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_rq,
  input  logic [ADDR_WIDTH-1:0] r_address,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  read_err,
  output logic                  write_err,
  output logic [DEPTH-1:0]      valid_mask,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  // Comparison width wide enough for both the full address and DEPTH, so
  // upper address bits always take part in the range check.
  localparam int CMP_W = (ADDR_WIDTH > 31) ? ADDR_WIDTH + 1 : 32;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  read_err_q, read_err_d;
  logic                  write_err_q, write_err_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;

  logic                  w_in_range;
  logic                  r_in_range;
  logic [DATA_WIDTH-1:0] rd_entry;
  logic                  rd_entry_valid;
  logic                  rd_good;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  collision;

  always_comb begin
    mem_d          = mem_q;
    valid_d        = valid_q;
    read_data_d    = read_data_q;
    read_valid_d   = 1'b0;
    read_err_d     = 1'b0;
    write_err_d    = 1'b0;
    wr_count_d     = wr_count_q;
    rd_count_d     = rd_count_q;
    rd_entry       = '0;
    rd_entry_valid = 1'b0;
    rd_good        = 1'b0;
    rd_value       = '0;

    w_in_range = CMP_W'(w_address) < CMP_W'(DEPTH);
    r_in_range = CMP_W'(r_address) < CMP_W'(DEPTH);
    collision  = write_rq && read_rq && w_in_range && r_in_range &&
                 (r_address == w_address);

    // Read lookup uses pre-write state; this is what makes the default
    // build read-first on a collision.
    for (int i = 0; i < DEPTH; i++) begin
      if (CMP_W'(r_address) == CMP_W'(i)) begin
        rd_entry       = mem_q[i];
        rd_entry_valid = valid_q[i];
      end
    end

    if (write_rq) begin
      if (w_in_range) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CMP_W'(w_address) == CMP_W'(i)) begin
            mem_d[i]   = write_data;
            valid_d[i] = 1'b1;
          end
        end
        if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
      end else begin
        write_err_d = 1'b1;
      end
    end

    if (read_rq) begin
      rd_good  = r_in_range && rd_entry_valid;
      rd_value = rd_entry;
`ifdef MEM_BYPASS_EN
      if (collision) begin
        rd_good  = 1'b1;
        rd_value = write_data;
      end
`endif
      if (rd_good) begin
        read_data_d  = rd_value;
        read_valid_d = 1'b1;
        if (rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
      end else begin
        read_data_d = '0;
        read_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      read_err_q   <= 1'b0;
      write_err_q  <= 1'b0;
      wr_count_q   <= '0;
      rd_count_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      valid_q      <= valid_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      read_err_q   <= read_err_d;
      write_err_q  <= write_err_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign read_err   = read_err_q;
  assign write_err  = write_err_q;
  assign valid_mask = valid_q;
  assign wr_count   = wr_count_q;
  assign rd_count   = rd_count_q;

endmodule
